// File: rtl/record_player_pkg.sv
// Shared constants for the note recorder and its playback engine: field widths,
// playback state encoding, the end-of-song marker and the duration rule.
package record_player_pkg;

    localparam int REC_CNT_BITS   = 4;
    localparam int OCTAVE_BITS    = 3;
    localparam int NOTE_BITS      = 4;
    localparam int LENGTH_BITS    = 3;
    localparam int FULL_NOTE_BITS = 3;

    // Holds the largest duration, 1 << (2**FULL_NOTE_BITS - 1) = 128 ticks.
    localparam int REMAIN_BITS    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PLAY  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // End-of-song marker: a rest (note 0) with length 0. A rest with a
    // non-zero length is a normal record.
    localparam logic [NOTE_BITS-1:0]   END_NOTE   = '0;
    localparam logic [LENGTH_BITS-1:0] END_LENGTH = '0;

    function automatic logic is_end_marker(input logic [NOTE_BITS-1:0]   note,
                                           input logic [LENGTH_BITS-1:0] length);
        return (note == END_NOTE) && (length == END_LENGTH);
    endfunction

    // Duration in ticks: 1 << (full_note - length), or 1 when length does not
    // fall below full_note. The extra bit keeps the subtraction from wrapping.
    function automatic logic [REMAIN_BITS-1:0] note_duration(
        input logic [FULL_NOTE_BITS-1:0] full_note,
        input logic [LENGTH_BITS-1:0]    length
    );
        logic [FULL_NOTE_BITS:0] fn_x;
        logic [FULL_NOTE_BITS:0] len_x;
        logic [FULL_NOTE_BITS:0] diff;
        fn_x  = (FULL_NOTE_BITS+1)'(full_note);
        len_x = (FULL_NOTE_BITS+1)'(length);
        diff  = fn_x - len_x;
        if (fn_x > len_x) begin
            return REMAIN_BITS'(1) << diff;
        end
        return REMAIN_BITS'(1);
    endfunction

endpackage

// File: rtl/record_player_tick_prescaler.sv
// Duration-tick prescaler: counts 0..TICK_DIV-1 while enabled and emits a
// one-cycle tick on the wrap. clr forces the count back to 0 so every note
// starts on a fresh tick boundary.
module tick_prescaler #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int                CNT_BITS = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_BITS-1:0] LAST   = CNT_BITS'(TICK_DIV - 1);

    logic [CNT_BITS-1:0] cnt_q;
    logic [CNT_BITS-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    // Next count: clear wins, otherwise advance and wrap while enabled.
    always_comb begin
        // NOTE: cnt_d gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/record_player.sv
// Playback engine: walks the record memory from index 0, holds each entry on
// the tone-generator outputs for its encoded duration and stops at an end
// marker, the last index, or on stop. All outputs are registered.
// Optional build macro RECORD_PLAYER_GAP_EN: silences note_active during the
// final tick of notes lasting two ticks or more (articulation gap).
module record_player
    import record_player_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic [OCTAVE_BITS-1:0]    octave_r,
    input  logic [NOTE_BITS-1:0]      note_r,
    input  logic [LENGTH_BITS-1:0]    length_r,
    input  logic [FULL_NOTE_BITS-1:0] full_note_r,
    output logic [REC_CNT_BITS-1:0]   rd_cnt,
    output logic                      rd_req,
    output logic [OCTAVE_BITS-1:0]    play_octave,
    output logic [NOTE_BITS-1:0]      play_note,
    output logic                      note_active,
    output logic                      busy,
    output logic                      done
);

`ifdef RECORD_PLAYER_GAP_EN
    localparam logic GAP_EN = 1'b1;
`else
    localparam logic GAP_EN = 1'b0;
`endif

    state_e                   state_q,       state_d;
    logic [REC_CNT_BITS-1:0]  rd_cnt_q,      rd_cnt_d;
    logic [OCTAVE_BITS-1:0]   play_octave_q, play_octave_d;
    logic [NOTE_BITS-1:0]     play_note_q,   play_note_d;
    logic                     note_active_q, note_active_d;
    logic                     busy_q,        busy_d;
    logic                     done_q,        done_d;
    logic [REMAIN_BITS-1:0]   remaining_q,   remaining_d;

    logic tick;
    logic presc_clr;
    logic presc_en;

    // The prescaler only runs in PLAY; any other state holds it at 0 so the
    // first tick of a note lands exactly TICK_DIV cycles after entering PLAY.
    assign presc_en  = (state_q == ST_PLAY);
    assign presc_clr = (state_q != ST_PLAY);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (presc_clr),
        .en    (presc_en),
        .tick  (tick)
    );

    assign rd_cnt      = rd_cnt_q;
    assign rd_req      = busy_q;
    assign play_octave = play_octave_q;
    assign play_note   = play_note_q;
    assign note_active = note_active_q;
    assign busy        = busy_q;
    assign done        = done_q;

    // Next-state and next-output logic; stop overrides every non-IDLE state.
    always_comb begin
        state_d       = state_q;
        rd_cnt_d      = rd_cnt_q;
        play_octave_d = play_octave_q;
        play_note_d   = play_note_q;
        note_active_d = note_active_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        remaining_d   = remaining_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d  = ST_FETCH;
                    rd_cnt_d = '0;
                    busy_d   = 1'b1;
                end
            end

            ST_FETCH: begin
                if (is_end_marker(note_r, length_r)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d       = ST_PLAY;
                    remaining_d   = note_duration(full_note_r, length_r);
                    play_octave_d = octave_r;
                    play_note_d   = note_r;
                    note_active_d = (note_r != '0);
                end
            end

            ST_PLAY: begin
                if (tick) begin
                    remaining_d = remaining_q - 1'b1;
                    // Entering the final tick of a note of two or more ticks.
                    if (GAP_EN && (remaining_q == REMAIN_BITS'(2))) begin
                        note_active_d = 1'b0;
                    end
                    if (remaining_q == REMAIN_BITS'(1)) begin
                        play_octave_d = '0;
                        play_note_d   = '0;
                        note_active_d = 1'b0;
                        if (rd_cnt_q == '1) begin
                            // Last index: finish without wrapping the index.
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d  = ST_FETCH;
                            rd_cnt_d = rd_cnt_q + 1'b1;
                        end
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (stop && (state_q != ST_IDLE)) begin
            state_d       = ST_IDLE;
            rd_cnt_d      = '0;
            play_octave_d = '0;
            play_note_d   = '0;
            note_active_d = 1'b0;
            busy_d        = 1'b0;
            done_d        = 1'b0;
            remaining_d   = '0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rd_cnt_q      <= '0;
            play_octave_q <= '0;
            play_note_q   <= '0;
            note_active_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            remaining_q   <= '0;
        end else begin
            state_q       <= state_d;
            rd_cnt_q      <= rd_cnt_d;
            play_octave_q <= play_octave_d;
            play_note_q   <= play_note_d;
            note_active_q <= note_active_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            remaining_q   <= remaining_d;
        end
    end

endmodule

// File: doc/record_player.md
# record_player

Playback engine for the note recorder. Walks the record memory from index 0, fetches each stored octave/note/length/full_note entry, and holds it on the tone-generator outputs for its encoded duration. Stops at an end-of-song marker, at the last index, or on request. Sits between the record memory's read port and the buzzer tone generator; recording and playback are mutually exclusive, and the top level muxes the memory index using `rd_req`.

## Interface
- `TICK_DIV`, default 25_000_000: clock cycles per duration tick; legal range ≥ 2.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: begin playback; sampled only in IDLE.
- `stop` in 1: abort playback; sampled in every state.
- `octave_r` in `OCTAVE_BITS`: record memory read data, combinational from `rd_cnt`.
- `note_r` in `NOTE_BITS`: record memory read data.
- `length_r` in `LENGTH_BITS`: record memory read data.
- `full_note_r` in `FULL_NOTE_BITS`: record memory read data.
- `rd_cnt` out `REC_CNT_BITS`: record index being fetched or played.
- `rd_req` out 1: player owns the memory index (equals `busy`).
- `play_octave` out `OCTAVE_BITS`: octave to the tone generator.
- `play_note` out `NOTE_BITS`: note to the tone generator; 0 means rest.
- `note_active` out 1: tone generator enable.
- `busy` out 1: playback in progress.
- `done` out 1: one-cycle pulse on normal completion.

## Operation
- States: IDLE, FETCH, PLAY, DONE.
- IDLE: `start` with no `stop` moves to FETCH, with `rd_cnt`=0.
- FETCH lasts 1 cycle. It latches all four fields from the read data.
  - End marker (`note_r`==0 and `length_r`==0): go to DONE.
  - Otherwise go to PLAY and load `remaining`=D.
- Duration: D = 1 << (full_note − length) when full_note > length; otherwise D = 1. Compute at width `FULL_NOTE_BITS`+1 to avoid underflow. D max is 128; `remaining` is 8 bits.
- PLAY:
  - `play_octave` and `play_note` show the latched fields.
  - `note_active` = (latched note ≠ 0).
  - The prescaler counts 0..TICK_DIV−1. Each wrap decrements `remaining`.
  - A wrap while `remaining`==1 ends the note:
    - If `rd_cnt` is the all-ones index: go to DONE.
    - Otherwise increment `rd_cnt` and go to FETCH.
- DONE lasts 1 cycle. `done`=1, `busy`=0, then go to IDLE. `rd_cnt` is held.
- `stop` in FETCH, PLAY or DONE: go to IDLE on the next edge. No `done` pulse. Outputs cleared.
- `start` while busy is ignored.
- `start` and `stop` in the same IDLE cycle: `stop` wins.

## Timing
- Reset (synchronous) clears every output: `rd_cnt`=0, `play_octave`=0, `play_note`=0, `note_active`=0, `busy`=0, `rd_req`=0, `done`=0. State = IDLE; prescaler and `remaining` = 0.
- Reset mid-playback behaves identically to reset, with no `done`.
- `busy` rises 1 cycle after `start` is sampled.
- Each played record occupies exactly 1 + D×TICK_DIV cycles. The prescaler clears on entering PLAY.
- Outputs are registered. Tone outputs change on the edge that enters PLAY and are zero in FETCH, IDLE and DONE.
- Read data is consumed only in FETCH, one cycle after `rd_cnt` settles.

## Configuration
- `RECORD_PLAYER_GAP_EN`
  - Defined: when D ≥ 2, `note_active` drops to 0 during the final tick of each note. This gives audible articulation between repeated notes. Total duration is unchanged.
  - Undefined: `note_active` stays high for the whole PLAY state of a non-rest note.

## Structure
- Shared package / `Constants.vh` holds:
  - `REC_CNT_BITS`, `OCTAVE_BITS`, `NOTE_BITS`, `LENGTH_BITS`, `FULL_NOTE_BITS`.
  - The state encoding localparams.
  - The end-marker definition (note 0, length 0), so recorder and player agree.
- One sub-module, `tick_prescaler`: parameter `TICK_DIV`; inputs `clr` and `en`; output a one-cycle `tick` pulse on wrap.

## Test plan
All scenarios use TICK_DIV=4 and a behavioural record memory.
- Single note, end marker at index 1. Record 0 = oct 4, note 3, length 2, full_note 4.
  - Start → `busy` next cycle, D=4, `note_active` high for 16 cycles, `play_note`=3.
  - Then FETCH of index 1 → `done` pulse → IDLE with `rd_cnt`=1.
- Rest record (note 0, length 1, full_note 4).
  - D=8, so 32 PLAY cycles with `note_active`=0.
  - Playback continues to the next index; a rest is not treated as an end marker.
- length ≥ full_note (length 5, full_note 4).
  - D=1, so 4 PLAY cycles.
  - With GAP_EN defined, `note_active` stays high: D<2, no gap.
- All indices non-marker.
  - Playback runs through the all-ones index, `done` pulses, and `rd_cnt` does not wrap to 0.
- `stop` asserted mid-PLAY.
  - Next cycle: IDLE, outputs zero, no `done`.
  - A later `start` restarts from index 0.
- Reset and input conflicts:
  - `rst_n` low mid-PLAY clears all outputs at the next edge.
  - `start`+`stop` together in IDLE leaves `busy`=0.
  - With `RECORD_PLAYER_GAP_EN` and D=4: `note_active` high for 12 cycles, then low for 4.
